// File: rtl/dti_apb_slave_regbank.sv
// APB slave register bank: configurable wait states, byte strobes, error
// response, read-only registers, per-register write pulses and protocol
// violation flag.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no transfer in progress; waiting for PSEL=1, PENABLE=0
// S_SETUP  | setup phase seen; expecting PENABLE=1 on this cycle
// S_ACCESS | access phase; counting wait states until PREADY
module dti_apb_slave_regbank #(
   parameter int                         APB_ADDR_WIDTH = 32,
   parameter int                         APB_DATA_WIDTH = 32,
   parameter int                         APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
   parameter int                         NUM_REGS       = 16,
   parameter int                         WAIT_CYCLES    = 0,
   parameter logic [NUM_REGS-1:0]        RO_MASK        = '0,
   parameter logic [APB_DATA_WIDTH-1:0]  RESET_VAL      = '0
) (
   input  logic                                PCLK,
   input  logic                                PRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]           PADDR,
   input  logic [APB_DATA_WIDTH-1:0]           PWDATA,
   input  logic [APB_STRB_WIDTH-1:0]           PSTRB,
   input  logic                                PSEL,
   input  logic                                PENABLE,
   input  logic                                PWRITE,
   output logic                                PREADY,
   output logic [APB_DATA_WIDTH-1:0]           PRDATA,
   output logic                                PSLVERR,
   output logic [NUM_REGS*APB_DATA_WIDTH-1:0]  reg_q,
   output logic [NUM_REGS-1:0]                 wr_pulse,
   output logic                                prot_err
);

   localparam int L     = $clog2(APB_STRB_WIDTH);
   localparam int IDX_W = $clog2(NUM_REGS);
   // Byte-offset bits below the word boundary; empty when the bus is 8 bits.
   localparam logic [APB_ADDR_WIDTH-1:0] LOW_MASK =
      APB_ADDR_WIDTH'((64'd1 << L) - 64'd1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } state_t;

   state_t                     state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [NUM_REGS-1:0]        wr_pulse_q, wr_pulse_d;
   logic                       prot_err_q, prot_err_d;
   logic [APB_DATA_WIDTH-1:0]  mem_q [NUM_REGS];
   logic [APB_DATA_WIDTH-1:0]  mem_d [NUM_REGS];

   logic [IDX_W-1:0]           idx;
   logic                       misalign;
   logic                       out_of_range;
   logic                       ro_hit;
   logic                       err;
   logic                       ready;
   logic                       commit;

   assign idx          = PADDR[L +: IDX_W];
   assign misalign     = |(PADDR & LOW_MASK);
   assign out_of_range = (PADDR >> (L + IDX_W)) != '0;
   assign ro_hit       = PWRITE & RO_MASK[idx];
   assign err          = misalign | out_of_range | ro_hit;

   // Ready depends only on registered state/count plus the live handshake.
   assign ready  = (state_q == S_ACCESS) & PSEL & PENABLE &
                   (cnt_q == 4'(WAIT_CYCLES));
   assign commit = ready & PWRITE & ~err;

   assign PREADY   = ready;
   assign PSLVERR  = ready & err;
   assign PRDATA   = (ready & ~PWRITE & ~err) ? mem_q[idx] : '0;
   assign wr_pulse = wr_pulse_q;
   assign prot_err = prot_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
         assign reg_q[gi*APB_DATA_WIDTH +: APB_DATA_WIDTH] = mem_q[gi];
      end
   endgenerate

   // Handshake FSM: next state, wait counter and protocol-violation detect.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prot_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (PSEL && !PENABLE) begin
               state_d = S_SETUP;
            end else if (PSEL && PENABLE) begin
               prot_err_d = 1'b1;
            end
         end
         S_SETUP: begin
            cnt_d = '0;
            if (PSEL && PENABLE) begin
               state_d = S_ACCESS;
            end else begin
               state_d    = S_IDLE;
               prot_err_d = PSEL;
            end
         end
         S_ACCESS: begin
            // Completion or master abort both end the transfer.
            if (ready || !PSEL || !PENABLE) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Register write path: strobe-masked merge and one-hot write pulse.
   always_comb begin
      mem_d      = mem_q;
      wr_pulse_d = '0;
      if (commit) begin
         wr_pulse_d[idx] = 1'b1;
         for (int b = 0; b < APB_STRB_WIDTH; b++) begin
            if (PSTRB[b]) begin
               mem_d[idx][b*8 +: 8] = PWDATA[b*8 +: 8];
            end
         end
      end
   end

   // State, counter, pulses and register bank.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wr_pulse_q <= '0;
         prot_err_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= RESET_VAL;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_pulse_q <= wr_pulse_d;
         prot_err_q <= prot_err_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_dti_apb_slave_regbank.sv
// Directed bench for dti_apb_slave_regbank: three instances with 0, 3 and 2
// wait states share the bus signals but each has its own PSEL.
module tb_dti_apb_slave_regbank;

   logic        clk;
   logic        rst_n;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  psel;
   logic        penable;
   logic        pwrite;

   logic [2:0]   pready;
   logic [2:0]   pslverr;
   logic [2:0]   prot_err;
   logic [31:0]  prdata [3];
   logic [511:0] regq   [3];
   logic [15:0]  wrp    [3];

   logic [31:0] rv [3];

   int n_checks;
   int n_errors;

   logic [31:0] rd;
   logic        er;
   int          wt;
   logic [15:0] wp;

   dti_apb_slave_regbank #(.WAIT_CYCLES(0), .RO_MASK(16'h0020), .RESET_VAL(32'h0000_0000)) u_dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
      .reg_q(regq[0]), .wr_pulse(wrp[0]), .prot_err(prot_err[0]));

   dti_apb_slave_regbank #(.WAIT_CYCLES(3), .RO_MASK(16'h0000), .RESET_VAL(32'hCAFE_0001)) u_dut1 (
      .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
      .reg_q(regq[1]), .wr_pulse(wrp[1]), .prot_err(prot_err[1]));

   dti_apb_slave_regbank #(.WAIT_CYCLES(2), .RO_MASK(16'h0000), .RESET_VAL(32'h0000_1234)) u_dut2 (
      .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]),
      .reg_q(regq[2]), .wr_pulse(wrp[2]), .prot_err(prot_err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rget(input int d, input int i);
      return regq[d][i*32 +: 32];
   endfunction

   // Full transfer on instance d; entered and left 1 time unit after an edge.
   task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           output logic [31:0] rdata, output logic slverr,
                           output int waits, output logic [15:0] pulse);
      psel    = '0;
      psel[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
      pstrb   = strb;
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      waits = 0;
      while (pready[d] !== 1'b1 && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      if (waits >= 20) check_val("ready_timeout", {63'd0, pready[d]}, 64'd1);
      rdata  = prdata[d];
      slverr = pslverr[d];
      @(posedge clk); #1;
      psel    = '0;
      penable = 1'b0;
      pulse   = wrp[d];
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rv[0] = 32'h0000_0000;
      rv[1] = 32'hCAFE_0001;
      rv[2] = 32'h0000_1234;
      rst_n = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
      psel = '0; penable = 1'b0; pwrite = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check_val("rst_pready",  {63'd0, pready[d]},   64'd0);
         check_val("rst_prdata",  {32'd0, prdata[d]},   64'd0);
         check_val("rst_pslverr", {63'd0, pslverr[d]},  64'd0);
         check_val("rst_wr_pulse",{48'd0, wrp[d]},      64'd0);
         check_val("rst_prot_err",{63'd0, prot_err[d]}, 64'd0);
         check_val("rst_regs",    {63'd0, regq[d] == {16{rv[d]}}}, 64'd1);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write then read of 0x08.
      apb_xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, rd, er, wt, wp);
      check_val("w08_err",   {63'd0, er}, 64'd0);
      check_val("w08_waits", wt,          0);
      check_val("w08_pulse", {48'd0, wp}, 64'h0004);
      check_val("w08_regq",  rget(0, 2),  32'hDEAD_BEEF);
      @(posedge clk); #1;
      check_val("w08_pulse_end", {48'd0, wrp[0]}, 64'd0);
      apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("r08_data",  rd,          32'hDEAD_BEEF);
      check_val("r08_err",   {63'd0, er}, 64'd0);
      check_val("r08_waits", wt,          0);
      check_val("r08_pulse", {48'd0, wp}, 64'd0);

      // Three wait states, read of reset value.
      apb_xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("ws3_waits", wt,          3);
      check_val("ws3_data",  rd,          32'hCAFE_0001);
      check_val("ws3_err",   {63'd0, er}, 64'd0);

      // Byte strobes, back-to-back transfers.
      apb_xfer(0, 1'b1, 32'h04, 32'h1122_3344, 4'hF, rd, er, wt, wp);
      apb_xfer(0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'h5, rd, er, wt, wp);
      check_val("strb_pulse", {48'd0, wp}, 64'h0002);
      apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("strb_data", rd, 32'h11BB_33DD);
      apb_xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'h0, rd, er, wt, wp);
      check_val("strb0_pulse", {48'd0, wp}, 64'h0002);
      check_val("strb0_regq",  rget(0, 1),  32'h11BB_33DD);

      // Error responses.
      apb_xfer(0, 1'b1, 32'h00, 32'h55AA_55AA, 4'hF, rd, er, wt, wp);
      apb_xfer(0, 1'b1, 32'h41, 32'h1234_5678, 4'hF, rd, er, wt, wp);
      check_val("mis_err",   {63'd0, er}, 64'd1);
      check_val("mis_pulse", {48'd0, wp}, 64'd0);
      check_val("mis_regq",  rget(0, 0),  32'h55AA_55AA);
      apb_xfer(0, 1'b0, 32'h41, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("mis_rd_err",  {63'd0, er}, 64'd1);
      check_val("mis_rd_data", rd,          32'h0);
      apb_xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("oor_err",  {63'd0, er}, 64'd1);
      check_val("oor_data", rd,          32'h0);
      apb_xfer(0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, rd, er, wt, wp);
      check_val("ro_err",   {63'd0, er}, 64'd1);
      check_val("ro_pulse", {48'd0, wp}, 64'd0);
      check_val("ro_regq",  rget(0, 5),  32'h0);
      apb_xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("ro_rd_err", {63'd0, er}, 64'd0);

      // Access phase without setup.
      psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08;
      @(posedge clk); #1;
      check_val("nosetup_prot",   {63'd0, prot_err[0]}, 64'd1);
      check_val("nosetup_pready", {63'd0, pready[0]},   64'd0);
      psel = '0; penable = 1'b0;
      @(posedge clk); #1;
      check_val("nosetup_prot_end", {63'd0, prot_err[0]}, 64'd0);
      apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("after_prot_data", rd, 32'hDEAD_BEEF);

      // Setup not followed by PENABLE.
      psel[0] = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      check_val("setup_hold_prot0", {63'd0, prot_err[0]}, 64'd0);
      @(posedge clk); #1;
      check_val("setup_hold_prot1", {63'd0, prot_err[0]}, 64'd1);
      psel = '0;
      @(posedge clk); #1;

      // Abort during wait states: no write.
      psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
      pwdata = 32'hFFFF_0000; pstrb = 4'hF;
      @(posedge clk); #1; penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      psel = '0; penable = 1'b0;
      @(posedge clk); #1;
      check_val("abort_pulse", {48'd0, wrp[1]}, 64'd0);
      check_val("abort_regq",  rget(1, 4),      32'hCAFE_0001);
      apb_xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("abort_rd",    rd, 32'hCAFE_0001);
      check_val("abort_waits", wt, 3);

      // Reset during the second wait cycle of a write.
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
      pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
      @(posedge clk); #1; penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_val("rstmid_pre_pready", {63'd0, pready[2]}, 64'd0);
      rst_n = 1'b0;
      #1;
      check_val("rstmid_pready",  {63'd0, pready[2]},   64'd0);
      check_val("rstmid_prdata",  {32'd0, prdata[2]},   64'd0);
      check_val("rstmid_pslverr", {63'd0, pslverr[2]},  64'd0);
      check_val("rstmid_pulse",   {48'd0, wrp[2]},      64'd0);
      check_val("rstmid_prot",    {63'd0, prot_err[2]}, 64'd0);
      check_val("rstmid_regq",    rget(2, 3),           32'h0000_1234);
      psel = '0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rstmid_after_pulse", {48'd0, wrp[2]}, 64'd0);
      apb_xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("rstmid_rd",    rd, 32'h0000_1234);
      check_val("rstmid_waits", wt, 2);
      apb_xfer(2, 1'b1, 32'h0C, 32'hA5A5_A5A5, 4'hF, rd, er, wt, wp);
      check_val("rstmid_w_pulse", {48'd0, wp}, 64'h0008);
      apb_xfer(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, wt, wp);
      check_val("rstmid_w_rd", rd, 32'hA5A5_A5A5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
